// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit general register file with two combinational read
// ports, one write port and a 16->32 sign-extend helper.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   read_addr_1/2     : read port indices, data_1/data_2 are the read data
//   write_addr/data   : write port, committed on clk when write_enabled=1
//   imm_in / imm_out  : immediate in, sign-extended immediate out
// Register 0 is hard-wired to zero. A write in flight is forwarded to any
// read port addressing the same register, except while rst is high.

module reg_file_rd_port (
   input  logic [31:0][31:0] regs,
   input  logic [4:0]        addr,
   input  logic              byp_en,
   input  logic [4:0]        write_addr,
   input  logic [31:0]       write_data,
   output logic [31:0]       data
);
   always_comb begin
      data = regs[addr];
      if (addr == 5'd0)
         data = '0;
      else if (byp_en && (write_addr == addr))
         data = write_data;
   end
endmodule

module reg_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  read_addr_1,
   input  logic [4:0]  read_addr_2,
   input  logic [4:0]  write_addr,
   input  logic [31:0] write_data,
   input  logic        write_enabled,
   output logic [31:0] data_1,
   output logic [31:0] data_2,
   input  logic [15:0] imm_in,
   output logic [31:0] imm_out
);
   localparam int NUM_RD = 2;

   logic [31:0][31:0]       regs_q, regs_d;
   logic [NUM_RD-1:0][4:0]  rd_addr;
   logic [NUM_RD-1:0][31:0] rd_data;
   logic                    wr_go;

   // A write only takes effect (and is only forwarded) outside reset and
   // never to register 0.
   assign wr_go = ~rst & write_enabled & (write_addr != 5'd0);

   always_comb begin
      regs_d = regs_q;
      if (rst)
         regs_d = '0;
      else if (wr_go)
         regs_d[write_addr] = write_data;
      // Keeps entry 0 at zero after the first edge, even if never reset.
      regs_d[0] = '0;
   end

   always_ff @(posedge clk)
      regs_q <= regs_d;

   assign rd_addr[0] = read_addr_1;
   assign rd_addr[1] = read_addr_2;

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      reg_file_rd_port u_rd (
         .regs       (regs_q),
         .addr       (rd_addr[g]),
         .byp_en     (wr_go),
         .write_addr (write_addr),
         .write_data (write_data),
         .data       (rd_data[g])
      );
   end

   assign data_1 = rd_data[0];
   assign data_2 = rd_data[1];

   assign imm_out = {{16{imm_in[15]}}, imm_in};
endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  read_addr_1, read_addr_2, write_addr;
   logic [31:0] write_data;
   logic        write_enabled;
   logic [31:0] data_1, data_2;
   logic [15:0] imm_in;
   logic [31:0] imm_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdl [32];

   always #5 clk = ~clk;

   reg_file dut (
      .clk(clk), .rst(rst),
      .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
      .write_addr(write_addr), .write_data(write_data),
      .write_enabled(write_enabled),
      .data_1(data_1), .data_2(data_2),
      .imm_in(imm_in), .imm_out(imm_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected read value from the register-file rules.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (!rst && write_enabled && write_addr == a) return write_data;
      return mdl[a];
   endfunction

   function automatic logic [31:0] exp_imm(input logic [15:0] i);
      if (i >= 16'h8000) return 32'hFFFF0000 + 32'(i);
      return 32'(i);
   endfunction

   task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [15:0] im);
      @(negedge clk);
      rst = r; write_enabled = we; write_addr = wa; write_data = wd;
      read_addr_1 = a1; read_addr_2 = a2; imm_in = im;
      #1;
   endtask

   task automatic chk_model();
      chk("rd1", data_1, exp_rd(read_addr_1));
      chk("rd2", data_2, exp_rd(read_addr_2));
      chk("imm", imm_out, exp_imm(imm_in));
   endtask

   // Advance one edge and apply the same edge to the reference model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      end else if (write_enabled && write_addr != 0) begin
         mdl[write_addr] = write_data;
      end
   endtask

   initial begin
      logic [4:0] wa, a1, a2;
      logic [15:0] imv [4];
      logic [31:0] imx [4];
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

      // Reset, then sweep every index on both ports.
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 32; i++) begin
         drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 16'(i));
         chk("rst_rd1", data_1, 32'h0);
         chk("rst_rd2", data_2, 32'h0);
         tick();
      end

      // Write reg 5, read it back on both ports next cycle.
      drive(0, 1, 5, 32'hDEADBEEF, 1, 2, 0);
      tick();
      drive(0, 0, 0, 0, 5, 5, 0);
      chk("r5_p1", data_1, 32'hDEADBEEF);
      chk("r5_p2", data_2, 32'hDEADBEEF);

      // Writes to reg 0 are dropped, including the bypass.
      drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
      chk("r0_byp1", data_1, 32'h0);
      chk("r0_byp2", data_2, 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("r0_rd", data_1, 32'h0);

      // Same-cycle bypass, then held after the edge.
      drive(0, 1, 7, 32'h12345678, 0, 7, 0);
      chk("byp7", data_2, 32'h12345678);
      tick();
      drive(0, 0, 7, 32'h0BADF00D, 7, 7, 0);
      chk("hold7_p1", data_1, 32'h12345678);
      chk("hold7_p2", data_2, 32'h12345678);

      // Reset beats a simultaneous write; no bypass while in reset.
      drive(0, 1, 3, 32'hA5A5A5A5, 0, 0, 0);
      tick();
      drive(1, 1, 3, 32'h1, 3, 3, 0);
      chk("rst_nobyp", data_1, 32'hA5A5A5A5);
      tick();
      drive(0, 0, 0, 0, 3, 5, 0);
      chk("rst_r3", data_1, 32'h0);
      chk("rst_r5", data_2, 32'h0);

      // Sign-extension corners.
      imv = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
      imx = '{32'h00007FFF, 32'hFFFF8000, 32'hFFFFFFFF, 32'h0};
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, imv[i]);
         chk("imm_corner", imout_wrap(), imx[i]);
      end
      tick();

      // Random traffic against the reference model.
      for (int n = 0; n < 800; n++) begin
         wa = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 40) == 0), 1'($urandom), wa, $urandom,
               a1, a2, 16'($urandom));
         chk_model();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic [31:0] imout_wrap();
      return imm_out;
   endfunction
endmodule
